// File: rtl/button_event_arbiter.sv
// Round-robin arbiter that turns per-button press pulses into
// single events handed to one consumer over valid/ready.
module button_event_arbiter #(
  parameter  int N_BTN  = 4,
  parameter  int DROP_W = 8,
  localparam int IDX_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  raised,
  input  logic              evt_ready,
  input  logic              drop_clr,
  output logic              evt_valid,
  output logic [IDX_W-1:0]  evt_idx,
  output logic [N_BTN-1:0]  pending,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_BTN - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [0:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [N_BTN-1:0]  pend_q, pend_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              grant;
  logic [N_BTN-1:0]  grant_mask;
  logic [N_BTN-1:0]  lost;

  // Search upward from rr_q with wrap; rr_q is always < N_BTN.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      j = int'(rr_q) + k;
      if (j >= N_BTN) begin
        j = j - N_BTN;
      end
      if (!pick_found && pend_q[j]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    grant      = (state_q == IDLE) && pick_found;
    grant_mask = '0;
    if (grant) begin
      grant_mask[pick_idx] = 1'b1;
    end
    lost   = raised & pend_q & ~grant_mask;
    pend_d = (pend_q & ~grant_mask) | raised;
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (pick_found) begin
          state_d = PRESENT;
          valid_d = 1'b1;
          idx_d   = pick_idx;
          rr_d    = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        end
      end
      (state_q == PRESENT): begin
        if (evt_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // One count per edge with any loss; clear wins over increment.
  always_comb begin
    drop_d = drop_q;
    if (drop_clr) begin
      drop_d = '0;
    end else if ((|lost) && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= '0;
      rr_q    <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_idx   = idx_q;
  assign pending   = pend_q;
  assign drop_cnt  = drop_q;

endmodule
